fetch_sequencer: RTL and testbench

Owns the fetch-stage program counter and decides each cycle's next fetch address. Chooses among sequential PC+4, branch/jump redirects resolved in D, exception entry and `eret` return. Applies the MIPS single delay slot correctly when instruction memory inserts wait cycles. Sits between the hazard unit, the D-stage branch comparator, CP0 and instruction memory, and drives the IF/ID register controls.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_addr_check.sv | 18 +
 rtl/fetch_sequencer.sv | 99 +++++++++
 tb/tb_fetch_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned IM_IDX_W = 12;
  localparam int unsigned EXC_W    = 5;

  typedef enum logic {
    SEQ  = 1'b0,
    PEND = 1'b1
  } fetch_state_e;

  localparam logic [EXC_W-1:0]  EXC_ADEL       = 5'd4;
  localparam logic [ADDR_W-1:0] PC_RESET_DEF   = 32'h0000_3000;
  localparam logic [ADDR_W-1:0] EXC_ENTRY_DEF  = 32'h0000_4180;
  localparam logic [ADDR_W-1:0] IM_BASE_DEF    = 32'h0000_3000;
  localparam logic [ADDR_W-1:0] IM_LIMIT_DEF   = 32'h0000_6ffc;

endpackage

// File: rtl/fetch_addr_check.sv
// Fetch address legality: misaligned or outside the instruction memory window.
module fetch_addr_check
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IM_BASE  = IM_BASE_DEF,
  parameter logic [ADDR_W-1:0] IM_LIMIT = IM_LIMIT_DEF
) (
  input  logic [ADDR_W-1:0] pc,
  output logic              f_adel,
  output logic [EXC_W-1:0]  f_exccode
);

  always_comb begin
    f_adel    = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
    f_exccode = f_adel ? EXC_ADEL : EXC_W'(0);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC owner: next-PC selection, delay-slot handling across
// instruction-memory waits, and IF/ID register controls.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_RESET  = PC_RESET_DEF,
  parameter logic [ADDR_W-1:0] EXC_ENTRY = EXC_ENTRY_DEF,
  parameter logic [ADDR_W-1:0] IM_BASE   = IM_BASE_DEF,
  parameter logic [ADDR_W-1:0] IM_LIMIT  = IM_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                im_wait,
  input  logic                d_is_jb,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_target,
  input  logic                exc_req,
  input  logic                eret_req,
  input  logic [ADDR_W-1:0]   epc,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   pc4,
  output logic [IM_IDX_W-1:0] im_addr,
  output logic                f_adel,
  output logic [EXC_W-1:0]    f_exccode,
  output logic                f_bd,
  output logic                fd_en,
  output logic                fd_bubble,
  output logic                fd_flush
);

  fetch_state_e      state, nxt_state;
  logic [ADDR_W-1:0] pend_target, nxt_pend;
  logic [ADDR_W-1:0] nxt_pc;

  assign pc4     = pc + ADDR_W'(4);
  assign im_addr = IM_IDX_W'((pc - IM_BASE) >> 2);
  assign f_bd    = d_is_jb || (state == PEND);

  fetch_addr_check #(
    .IM_BASE  (IM_BASE),
    .IM_LIMIT (IM_LIMIT)
  ) u_addr_check (
    .pc        (pc),
    .f_adel    (f_adel),
    .f_exccode (f_exccode)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= PC_RESET;
      state       <= SEQ;
      pend_target <= '0;
    end else begin
      pc          <= nxt_pc;
      state       <= nxt_state;
      pend_target <= nxt_pend;
    end
  end

  // A redirect seen while the delay slot is still waiting on memory is parked
  // in pend_target and applied once that slot fetch completes.
  always_comb begin
    nxt_pc    = pc;
    nxt_state = state;
    nxt_pend  = pend_target;
    fd_en     = !stall;
    fd_bubble = 1'b0;
    fd_flush  = 1'b0;

    if (exc_req) begin
      nxt_pc    = EXC_ENTRY;
      nxt_state = SEQ;
      fd_flush  = 1'b1;
    end else if (eret_req) begin
      nxt_pc    = epc;
      nxt_state = SEQ;
      fd_flush  = 1'b1;
    end else if (stall) begin
      nxt_pc    = pc;
    end else if (im_wait) begin
      fd_bubble = 1'b1;
      if ((state == SEQ) && redirect) begin
        nxt_pend  = redirect_target;
        nxt_state = PEND;
      end
    end else begin
      nxt_state = SEQ;
      if (state == PEND) begin
        nxt_pc = pend_target;
      end else if (redirect) begin
        nxt_pc = redirect_target;
      end else begin
        nxt_pc = pc4;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expected values.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, im_wait, d_is_jb, redirect, exc_req, eret_req;
  logic [31:0] redirect_target, epc;
  logic [31:0] pc, pc4;
  logic [11:0] im_addr;
  logic        f_adel, f_bd, fd_en, fd_bubble, fd_flush;
  logic [4:0]  f_exccode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .im_wait         (im_wait),
    .d_is_jb         (d_is_jb),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .exc_req         (exc_req),
    .eret_req        (eret_req),
    .epc             (epc),
    .pc              (pc),
    .pc4             (pc4),
    .im_addr         (im_addr),
    .f_adel          (f_adel),
    .f_exccode       (f_exccode),
    .f_bd            (f_bd),
    .fd_en           (fd_en),
    .fd_bubble       (fd_bubble),
    .fd_flush        (fd_flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; im_wait = 0; d_is_jb = 0; redirect = 0;
    exc_req = 0; eret_req = 0;
  endtask

  initial begin
    reset = 1'b1;
    redirect_target = '0;
    epc = '0;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    check("rst_pc", pc, 32'h3000);
    check("rst_pc4", pc4, 32'h3004);
    check("rst_im_addr", 32'(im_addr), 0);
    check("rst_adel", 32'(f_adel), 0);
    check("rst_exccode", 32'(f_exccode), 0);
    check("rst_bd", 32'(f_bd), 0);
    check("rst_fd_en", 32'(fd_en), 1);
    check("rst_bubble", 32'(fd_bubble), 0);
    check("rst_flush", 32'(fd_flush), 0);
    d_is_jb = 1; #1;
    check("rst_bd_jb", 32'(f_bd), 1);
    d_is_jb = 0;

    // sequential fetch
    step(); check("seq_pc1", pc, 32'h3004); check("seq_im1", 32'(im_addr), 1);
    step(); check("seq_pc2", pc, 32'h3008);

    // redirect with no waits
    d_is_jb = 1; redirect = 1; redirect_target = 32'h3100; #1;
    check("rd_bd", 32'(f_bd), 1);
    step(); idle();
    check("rd_pc", pc, 32'h3100);
    step(); check("rd_seq", pc, 32'h3104);

    // redirect while the delay slot waits on memory
    d_is_jb = 1; redirect = 1; redirect_target = 32'h3200; im_wait = 1; #1;
    check("wt_bubble0", 32'(fd_bubble), 1);
    check("wt_fd_en0", 32'(fd_en), 1);
    step();
    d_is_jb = 0; redirect = 1; redirect_target = 32'h3300; #1;
    check("wt_hold1", pc, 32'h3104);
    check("wt_bd_pend", 32'(f_bd), 1);
    check("wt_bubble1", 32'(fd_bubble), 1);
    step(); idle(); #1;
    check("wt_hold2", pc, 32'h3104);
    check("wt_bd_pend2", 32'(f_bd), 1);
    check("wt_bubble_off", 32'(fd_bubble), 0);
    step();
    check("wt_target", pc, 32'h3200);
    check("wt_bd_clear", 32'(f_bd), 0);

    // stall ignores redirect
    stall = 1; redirect = 1; redirect_target = 32'h3400; #1;
    check("st_fd_en", 32'(fd_en), 0);
    step(); check("st_hold1", pc, 32'h3200);
    step(); check("st_hold2", pc, 32'h3200);
    check("st_no_pend", 32'(f_bd), 0);

    // exception overrides stall and im_wait
    redirect = 0; exc_req = 1; im_wait = 1; #1;
    check("ex_flush", 32'(fd_flush), 1);
    check("ex_no_bubble", 32'(fd_bubble), 0);
    step(); idle();
    check("ex_pc", pc, 32'h4180);
    check("ex_adel", 32'(f_adel), 0);

    // eret while a redirect is pending
    redirect = 1; redirect_target = 32'h3500; im_wait = 1;
    step(); idle(); #1;
    check("er_pend_pc", pc, 32'h4180);
    check("er_pend_bd", 32'(f_bd), 1);
    eret_req = 1; epc = 32'h3024; #1;
    check("er_flush", 32'(fd_flush), 1);
    step(); idle();
    check("er_pc", pc, 32'h3024);
    check("er_bd", 32'(f_bd), 0);
    step(); check("er_discard", pc, 32'h3028);

    // exc_req beats eret_req
    exc_req = 1; eret_req = 1; epc = 32'h3600;
    step(); idle();
    check("exer_pc", pc, 32'h4180);

    // address faults
    redirect = 1; redirect_target = 32'h3002;
    step(); idle();
    check("mis_pc", pc, 32'h3002);
    check("mis_adel", 32'(f_adel), 1);
    check("mis_code", 32'(f_exccode), 4);
    check("mis_im", 32'(im_addr), 0);
    step(); check("mis_next", pc, 32'h3006);
    redirect = 1; redirect_target = 32'h6ffc;
    step(); idle();
    check("lim_adel", 32'(f_adel), 0);
    check("lim_code", 32'(f_exccode), 0);
    check("lim_im", 32'(im_addr), 32'hfff);
    step();
    check("hi_pc", pc, 32'h7000);
    check("hi_adel", 32'(f_adel), 1);
    check("hi_code", 32'(f_exccode), 4);
    redirect = 1; redirect_target = 32'h2ffc;
    step(); idle();
    check("lo_adel", 32'(f_adel), 1);
    redirect = 1; redirect_target = 32'hffff_fffc;
    step(); idle();
    check("wrap_pc4", pc4, 32'h0);
    step(); check("wrap_pc", pc, 32'h0);

    // asynchronous reset while a redirect is pending
    redirect = 1; redirect_target = 32'h3700; im_wait = 1;
    step(); idle();
    #3 reset = 1'b1;
    #1;
    check("ar_pc", pc, 32'h3000);
    check("ar_bd", 32'(f_bd), 0);
    @(posedge clk); #1 reset = 1'b0;
    check("ar_hold", pc, 32'h3000);
    step(); check("ar_seq", pc, 32'h3004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
